// File: rtl/hazard_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit_if
// Description : Bundle of the decode-side hazard inputs and the pipeline
//               control outputs shared by the hazard control unit and the
//               pipeline that hosts it.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_control_unit_if #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 16
);
  logic              en_pipeline_i;
  logic [NB_REG-1:0] id_rs_i;
  logic [NB_REG-1:0] id_rt_i;
  logic              id_uses_rt_i;
  logic [NB_REG-1:0] ex_rw_i;
  logic              ex_mem_read_i;
  logic              branch_taken_i;
  logic              halt_i;
  logic              pc_write_o;
  logic              ifid_write_o;
  logic              ifid_flush_o;
  logic              idex_bubble_o;
  logic              halted_o;
  logic [NB_CNT-1:0] stall_count_o;

  // Pipeline side: supplies decode information, consumes control.
  modport master (
    output en_pipeline_i, id_rs_i, id_rt_i, id_uses_rt_i, ex_rw_i,
           ex_mem_read_i, branch_taken_i, halt_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           halted_o, stall_count_o
  );

  // Hazard unit side.
  modport slave (
    input  en_pipeline_i, id_rs_i, id_rt_i, id_uses_rt_i, ex_rw_i,
           ex_mem_read_i, branch_taken_i, halt_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           halted_o, stall_count_o
  );
endinterface
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : Load-use stall, taken-branch flush and HALT drain control for
//               the IF/ID, ID/EX stage registers and the PC. State advances
//               on the falling clock edge, matching the stage registers.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit #(
  parameter int NB_REG       = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int NB_CNT       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  hazard_control_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        drain_cnt;
  logic [NB_CNT-1:0] stall_count;
  logic              halted;

  logic [NB_REG-1:0] id_rs;
  logic [NB_REG-1:0] id_rt;
  logic [NB_REG-1:0] ex_rw;
  logic              load_use;
  logic              en;

  assign id_rs = bus.id_rs_i;
  assign id_rt = bus.id_rt_i;
  assign ex_rw = bus.ex_rw_i;
  assign en    = bus.en_pipeline_i;

  // A load into r0 never creates a dependency; rt only matters when read.
  assign load_use = bus.ex_mem_read_i && (ex_rw != '0) &&
                    ((ex_rw == id_rs) || (bus.id_uses_rt_i && (ex_rw == id_rt)));

  // Next-state, drain countdown and saturating stall/flush event counter.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      drain_cnt   <= 3'd0;
      stall_count <= '0;
      halted      <= 1'b0;
    end else if (en) begin
      case (state)
        RUN: begin
          // A taken branch wins: the decode instruction is wrong-path.
          if (bus.branch_taken_i || load_use) begin
            if (stall_count != '1) stall_count <= stall_count + 1'b1;
          end else if (bus.halt_i) begin
            state     <= DRAIN;
            drain_cnt <= 3'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 3'd1;
          if (drain_cnt == 3'd1) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Decode of stage-register enables from state and current hazards.
  always_comb begin
    bus.pc_write_o    = 1'b0;
    bus.ifid_write_o  = 1'b0;
    bus.ifid_flush_o  = 1'b0;
    bus.idex_bubble_o = 1'b0;
    if (!reset) begin
      bus.idex_bubble_o = 1'b1;
    end else if (en) begin
      case (state)
        RUN: begin
          if (bus.branch_taken_i) begin
            bus.pc_write_o    = 1'b1;
            bus.ifid_write_o  = 1'b1;
            bus.ifid_flush_o  = 1'b1;
            bus.idex_bubble_o = 1'b1;
          end else if (load_use) begin
            bus.idex_bubble_o = 1'b1;
          end else if (!bus.halt_i) begin
            bus.pc_write_o    = 1'b1;
            bus.ifid_write_o  = 1'b1;
          end
        end
        default: begin
          bus.idex_bubble_o = 1'b1;
        end
      endcase
    end
  end

  assign bus.halted_o      = halted;
  assign bus.stall_count_o = stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Self-checking bench for hazard_control_unit with directed and
//               randomized stimulus against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;

  localparam int NB_REG = 5;
  localparam int NB_CNT = 16;
  localparam int DRAIN  = 3;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  hazard_control_unit_if #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) hif ();

  hazard_control_unit #(
    .NB_REG(NB_REG), .DRAIN_CYCLES(DRAIN), .NB_CNT(NB_CNT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (hif.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: halted flag, enabled edges left before halting
  // (0 = not draining), and the number of stall/flush events seen.
  bit m_halted;
  int m_drain_left;
  int m_stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_halted     = 1'b0;
    m_drain_left = 0;
    m_stalls     = 0;
  endtask

  // One clock: drive at the rising edge, check decode before the falling edge,
  // advance the model on the falling edge, then check registered outputs.
  task automatic step(input bit en, input logic [4:0] rs, input logic [4:0] rt,
                      input bit urt, input logic [4:0] rw, input bit mr,
                      input bit br, input bit hl, input bit do_chk);
    bit lu, running;
    bit e_pc, e_ifw, e_fl, e_bub;
    @(posedge clock);
    hif.en_pipeline_i  = en;
    hif.id_rs_i        = rs;
    hif.id_rt_i        = rt;
    hif.id_uses_rt_i   = urt;
    hif.ex_rw_i        = rw;
    hif.ex_mem_read_i  = mr;
    hif.branch_taken_i = br;
    hif.halt_i         = hl;
    #1;
    lu      = mr && (rw != 0) && (rw == rs || (urt && rw == rt));
    running = !m_halted && (m_drain_left == 0);
    {e_pc, e_ifw, e_fl, e_bub} = 4'b0000;
    if (en) begin
      if (!running)  {e_pc, e_ifw, e_fl, e_bub} = 4'b0001;
      else if (br)   {e_pc, e_ifw, e_fl, e_bub} = 4'b1111;
      else if (lu)   {e_pc, e_ifw, e_fl, e_bub} = 4'b0001;
      else if (hl)   {e_pc, e_ifw, e_fl, e_bub} = 4'b0000;
      else           {e_pc, e_ifw, e_fl, e_bub} = 4'b1100;
    end
    if (do_chk) begin
      chk("pc_write",    32'(hif.pc_write_o),    32'(e_pc));
      chk("ifid_write",  32'(hif.ifid_write_o),  32'(e_ifw));
      chk("ifid_flush",  32'(hif.ifid_flush_o),  32'(e_fl));
      chk("idex_bubble", 32'(hif.idex_bubble_o), 32'(e_bub));
    end
    @(negedge clock);
    if (en) begin
      if (m_drain_left > 0) begin
        m_drain_left = m_drain_left - 1;
        if (m_drain_left == 0) m_halted = 1'b1;
      end else if (!m_halted) begin
        if (br || lu)  m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
        else if (hl)   m_drain_left = DRAIN;
      end
    end
    #1;
    if (do_chk) begin
      chk("halted",      32'(hif.halted_o),      32'(m_halted));
      chk("stall_count", 32'(hif.stall_count_o), 32'(m_stalls));
    end
  endtask

  task automatic rand_step(input int halt_pct);
    step(($urandom_range(0, 99) < 85), 5'($urandom_range(0, 3)),
         5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
         1'($urandom), ($urandom_range(0, 99) < 15),
         ($urandom_range(0, 99) < halt_pct), 1'b1);
  endtask

  initial begin
    int first_halt;

    // Reset asserted: forced decode values, cleared registers.
    reset = 1'b0;
    hif.en_pipeline_i  = 1'b1;
    hif.id_rs_i        = '0;
    hif.id_rt_i        = '0;
    hif.id_uses_rt_i   = 1'b0;
    hif.ex_rw_i        = '0;
    hif.ex_mem_read_i  = 1'b0;
    hif.branch_taken_i = 1'b0;
    hif.halt_i         = 1'b0;
    model_reset();
    #12;
    chk("rst_pc_write",    32'(hif.pc_write_o),    32'd0);
    chk("rst_ifid_write",  32'(hif.ifid_write_o),  32'd0);
    chk("rst_ifid_flush",  32'(hif.ifid_flush_o),  32'd0);
    chk("rst_idex_bubble", 32'(hif.idex_bubble_o), 32'd1);
    chk("rst_halted",      32'(hif.halted_o),      32'd0);
    chk("rst_stall_count", 32'(hif.stall_count_o), 32'd0);
    @(posedge clock);
    reset = 1'b1;

    // Load-use on rs, then the following cycle runs freely.
    step(1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 1);
    chk("lu_count_one", 32'(hif.stall_count_o), 32'd1);
    step(1, 5'd5, 5'd0, 0, 5'd5, 0, 0, 0, 1);
    // No false hazards: r0 destination, rt not read.
    step(1, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 1);
    step(1, 5'd3, 5'd5, 0, 5'd5, 1, 0, 0, 1);
    // Hazard through rt when it is read.
    step(1, 5'd3, 5'd5, 1, 5'd5, 1, 0, 0, 1);
    // Branch overrides both load-use and halt; core keeps running.
    step(1, 5'd5, 5'd5, 1, 5'd5, 1, 1, 1, 1);
    step(1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1);
    // Frozen pipeline with an active load-use.
    step(0, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 1);
    step(0, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 1);

    // Randomized running traffic, no halts.
    for (int i = 0; i < 400; i++) rand_step(0);

    // Halt drain with two disabled cycles in the middle.
    step(1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 1);
    first_halt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (first_halt == 0) begin
        step((i != 2 && i != 3), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             1'($urandom), 1'b1);
        if (hif.halted_o === 1'b1) first_halt = i;
      end
    end
    chk("halt_latency", 32'(first_halt), 32'd5);
    for (int i = 0; i < 10; i++) rand_step(50);

    // Asynchronous reset while halted, between clock edges.
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_halted",      32'(hif.halted_o),      32'd0);
    chk("arst_idex_bubble", 32'(hif.idex_bubble_o), 32'd1);
    chk("arst_pc_write",    32'(hif.pc_write_o),    32'd0);
    chk("arst_stall_count", 32'(hif.stall_count_o), 32'd0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    step(1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1);

    // Saturation of the stall counter.
    for (int i = 0; i < 65540; i++) step(1, 5'd7, 5'd0, 0, 5'd7, 1, 0, 0, 0);
    chk("sat_model", 32'(hif.stall_count_o), 32'(m_stalls));
    chk("sat_ffff",  32'(hif.stall_count_o), 32'h0000_FFFF);
    step(1, 5'd7, 5'd0, 0, 5'd7, 1, 1, 0, 1);

    // Randomized traffic including occasional halts.
    for (int i = 0; i < 300; i++) rand_step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
